oled_iic_writer: RTL and testbench

I2C write engine for the SSD1306-class OLED path. It accepts one command/data transfer per handshake: control byte plus payload byte. It serialises START, slave address with W, control byte, payload byte and STOP onto `iic_scl`/`iic_sda`, and checks the slave ACK after every byte. It sits directly downstream of the OLED driver's init/refresh sequencer, which feeds it one byte pair at a time and waits on `busy`.

---
 rtl/oled_iic_writer.sv | 163 ++++++++++++++++
 tb/tb_oled_iic_writer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_iic_writer.sv
// I2C write engine for the OLED path: START, 8'h78, control byte, payload byte, STOP,
// with slave ACK checked after every byte.
`timescale 1ns/1ps
module oled_iic_writer #(
    parameter int         CLK_HZ     = 50_000_000,
    parameter int         SCL_HZ     = 400_000,
    parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] ctrl_byte,
    input  logic [7:0] data_byte,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       iic_scl,
    inout  wire        iic_sda,
    output logic [2:0] dbg_state
);

    localparam int DIV = CLK_HZ / (SCL_HZ * 4);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [7:0] ADDR_W = {SLAVE_ADDR, 1'b0};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_BIT   = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // Handshake: start is taken only in IDLE (busy=0); busy stays high from the cycle
    // after the accept until the single DONE cycle, where done pulses and busy is low.
    logic [2:0]    state;
    logic [1:0]    quarter;
    logic [CW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic [1:0]    byte_idx;
    logic [7:0]    shreg;
    logic [7:0]    ctrl_q;
    logic [7:0]    data_q;
    logic          tick;

    logic scl_d, sda_d, oe_d;
    logic scl_q, sda_q, oe_q;

    assign tick      = (div_cnt == CW'(DIV - 1));
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);
    assign dbg_state = state;
    assign iic_scl   = scl_q;
    assign iic_sda   = oe_q ? sda_q : 1'bz;

    // Line levels per quarter; registered below so the pins never see decode glitches.
    always_comb begin
        scl_d = 1'b1;
        sda_d = 1'b1;
        oe_d  = 1'b1;
        case (state)
            S_START: begin
                scl_d = (quarter != 2'd3);
                sda_d = (quarter < 2'd2);
            end
            S_BIT: begin
                scl_d = quarter[1];
                sda_d = shreg[7];
            end
            S_ACK: begin
                scl_d = quarter[1];
                oe_d  = 1'b0;
            end
            S_STOP: begin
                scl_d = (quarter != 2'd0);
                sda_d = quarter[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
            oe_q  <= 1'b1;
        end else begin
            scl_q <= scl_d;
            sda_q <= sda_d;
            oe_q  <= oe_d;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            quarter  <= 2'd0;
            div_cnt  <= '0;
            bit_cnt  <= 3'd0;
            byte_idx <= 2'd0;
            shreg    <= 8'h00;
            ctrl_q   <= 8'h00;
            data_q   <= 8'h00;
            ack_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_START;
                        quarter  <= 2'd0;
                        div_cnt  <= '0;
                        bit_cnt  <= 3'd0;
                        byte_idx <= 2'd0;
                        shreg    <= ADDR_W;
                        ctrl_q   <= ctrl_byte;
                        data_q   <= data_byte;
                        ack_err  <= 1'b0;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: begin
                    if (!tick) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        quarter <= quarter + 2'd1;
                        // ACK is sampled at the end of q2, while SCL is high.
                        if (state == S_ACK && quarter == 2'd2 && iic_sda !== 1'b0)
                            ack_err <= 1'b1;
                        if (quarter == 2'd3) begin
                            case (state)
                                S_START: begin
                                    state   <= S_BIT;
                                    bit_cnt <= 3'd0;
                                end
                                S_BIT: begin
                                    if (bit_cnt == 3'd7) begin
                                        state <= S_ACK;
                                    end else begin
                                        bit_cnt <= bit_cnt + 3'd1;
                                        shreg   <= {shreg[6:0], 1'b0};
                                    end
                                end
                                S_ACK: begin
                                    bit_cnt <= 3'd0;
                                    if (ack_err || byte_idx == 2'd2) begin
                                        state <= S_STOP;
                                    end else begin
                                        state    <= S_BIT;
                                        byte_idx <= byte_idx + 2'd1;
                                        shreg    <= (byte_idx == 2'd0) ? ctrl_q : data_q;
                                    end
                                end
                                S_STOP:  state <= S_DONE;
                                default: state <= S_IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oled_iic_writer.sv
// Directed bench for oled_iic_writer: bus monitor decodes bytes/START/STOP and acts as
// the ACKing (or NACKing) slave; each scenario task checks its own results.
`timescale 1ns/1ps
module tb_oled_iic_writer;

    localparam int DIV      = 31;
    localparam int FULL_LAT = 116 * DIV;
    localparam int NACK_LAT = 44 * DIV;

    logic       clk_50m = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] ctrl_byte = 8'h00;
    logic [7:0] data_byte = 8'h00;
    logic       busy, done, ack_err, iic_scl;
    wire        iic_sda;
    logic [2:0] dbg_state;

    int comps = 0;
    int errs  = 0;
    int cyc   = 0;
    int t_acc = 0;
    int lat   = 0;
    int start_cnt = 0;
    int stop_cnt  = 0;
    int done_cnt  = 0;
    int nack_byte = -1;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    logic ack_slot   = 1'b0;
    logic ack_hi     = 1'b0;
    logic slave_nack = 1'b0;

    // Slave drives the ACK slot (1 stands in for the pull-up on a NACK) and lets go
    // the instant SCL falls after the ninth clock pulse.
    assign iic_sda = (ack_slot && !(ack_hi && !iic_scl)) ? slave_nack : 1'bz;

    oled_iic_writer dut (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .start     (start),
        .ctrl_byte (ctrl_byte),
        .data_byte (data_byte),
        .busy      (busy),
        .done      (done),
        .ack_err   (ack_err),
        .iic_scl   (iic_scl),
        .iic_sda   (iic_sda),
        .dbg_state (dbg_state)
    );

    always #10 clk_50m = ~clk_50m;
    always @(posedge clk_50m) cyc <= cyc + 1;

    initial begin
        logic p_scl, p_sda, scl, sda;
        int bits, byte_i;
        logic [7:0] sh;
        p_scl = 1'b1; p_sda = 1'b1; bits = 0; byte_i = 0; sh = 8'h00;
        forever begin
            @(negedge clk_50m);
            scl = iic_scl;
            sda = (iic_sda === 1'b0) ? 1'b0 : 1'b1;
            if (done === 1'b1) done_cnt++;
            if (!rst_n) begin
                ack_slot = 1'b0; ack_hi = 1'b0; bits = 0; byte_i = 0;
            end else begin
                if (p_scl && scl && p_sda && !sda) begin
                    start_cnt++; bits = 0; byte_i = 0; ack_slot = 1'b0; ack_hi = 1'b0;
                end else if (p_scl && scl && !p_sda && sda) begin
                    stop_cnt++;
                end
                if (!p_scl && scl) begin
                    if (ack_slot) begin
                        ack_hi = 1'b1;
                    end else if (bits < 8) begin
                        sh = {sh[6:0], sda};
                        bits++;
                        if (bits == 8) got_q.push_back(sh);
                    end
                end
                if (p_scl && !scl) begin
                    if (ack_slot) begin
                        ack_slot = 1'b0; ack_hi = 1'b0; bits = 0; byte_i++;
                    end else if (bits == 8) begin
                        slave_nack = (byte_i == nack_byte);
                        ack_slot = 1'b1;
                    end
                end
            end
            p_scl = scl;
            p_sda = sda;
        end
    end

    task automatic accept_xfer(input logic [7:0] c, input logic [7:0] d);
        @(negedge clk_50m);
        start = 1'b1; ctrl_byte = c; data_byte = d;
        @(posedge clk_50m);
        #1;
        t_acc = cyc;
        start_cnt = 0; stop_cnt = 0; done_cnt = 0;
        got_q.delete();
    endtask

    task automatic wait_done(input int budget);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_50m);
            if (done === 1'b1) begin
                lat = cyc - t_acc;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int bad;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_50m);
        comps++; if (iic_scl !== 1'b1) begin errs++; $display("FAIL rst_scl: got %b want 1", iic_scl); end
        comps++; if (iic_sda !== 1'b1) begin errs++; $display("FAIL rst_sda: got %b want 1", iic_sda); end
        comps++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", busy); end
        comps++; if (done !== 1'b0) begin errs++; $display("FAIL rst_done: got %b want 0", done); end
        comps++; if (ack_err !== 1'b0) begin errs++; $display("FAIL rst_ack_err: got %b want 0", ack_err); end
        rst_n = 1'b1;
        bad = 0;
        repeat (1000) begin
            @(negedge clk_50m);
            if (iic_scl !== 1'b1 || iic_sda !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ack_err !== 1'b0)
                bad++;
        end
        comps++; if (bad != 0) begin errs++; $display("FAIL idle_1000: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_full_ack;
        nack_byte = -1;
        accept_xfer(8'h00, 8'hAF);
        @(negedge clk_50m);
        start = 1'b0;
        comps++; if (busy !== 1'b1) begin errs++; $display("FAIL full_busy_rise: got %b want 1", busy); end
        wait_done(4000);
        comps++; if (lat != FULL_LAT) begin errs++; $display("FAIL full_latency: got %0d want %0d", lat, FULL_LAT); end
        comps++; if (busy !== 1'b0) begin errs++; $display("FAIL full_busy_at_done: got %b want 0", busy); end
        repeat (5) @(negedge clk_50m);
        comps++; if (ack_err !== 1'b0) begin errs++; $display("FAIL full_ack_err: got %b want 0", ack_err); end
        exp_q = '{8'h78, 8'h00, 8'hAF};
        comps++; if (got_q.size() != exp_q.size()) begin errs++; $display("FAIL full_nbytes: got %0d want %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            comps++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL full_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        comps++; if (start_cnt != 1) begin errs++; $display("FAIL full_starts: got %0d want 1", start_cnt); end
        comps++; if (stop_cnt != 1) begin errs++; $display("FAIL full_stops: got %0d want 1", stop_cnt); end
        comps++; if (done_cnt != 1) begin errs++; $display("FAIL full_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_nack_addr;
        nack_byte = 0;
        accept_xfer(8'h00, 8'hAF);
        @(negedge clk_50m);
        start = 1'b0;
        wait_done(4000);
        comps++; if (lat != NACK_LAT) begin errs++; $display("FAIL nack_latency: got %0d want %0d", lat, NACK_LAT); end
        comps++; if (ack_err !== 1'b1) begin errs++; $display("FAIL nack_ack_err: got %b want 1", ack_err); end
        repeat (5) @(negedge clk_50m);
        comps++; if (got_q.size() != 1) begin errs++; $display("FAIL nack_nbytes: got %0d want 1", got_q.size()); end
        else begin
            comps++; if (got_q[0] !== 8'h78) begin errs++; $display("FAIL nack_byte0: got %h want 78", got_q[0]); end
        end
        comps++; if (stop_cnt != 1) begin errs++; $display("FAIL nack_stops: got %0d want 1", stop_cnt); end
        nack_byte = -1;
    endtask

    task automatic test_ack_err_clear;
        comps++; if (ack_err !== 1'b1) begin errs++; $display("FAIL err_hold: got %b want 1", ack_err); end
        accept_xfer(8'h40, 8'hC3);
        @(negedge clk_50m);
        start = 1'b0;
        comps++; if (ack_err !== 1'b0) begin errs++; $display("FAIL err_clear: got %b want 0", ack_err); end
        wait_done(4000);
        comps++; if (lat != FULL_LAT) begin errs++; $display("FAIL clr_latency: got %0d want %0d", lat, FULL_LAT); end
        repeat (5) @(negedge clk_50m);
        comps++; if (start_cnt != 1) begin errs++; $display("FAIL sda_while_scl_hi_starts: got %0d want 1", start_cnt); end
        comps++; if (stop_cnt != 1) begin errs++; $display("FAIL sda_while_scl_hi_stops: got %0d want 1", stop_cnt); end
        exp_q = '{8'h78, 8'h40, 8'hC3};
        comps++; if (got_q.size() != exp_q.size()) begin errs++; $display("FAIL clr_nbytes: got %0d want %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            comps++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL clr_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_ignore_start;
        accept_xfer(8'h00, 8'h5A);
        @(negedge clk_50m);
        start = 1'b0;
        repeat (20 * DIV) @(negedge clk_50m);
        start = 1'b1; ctrl_byte = 8'h40; data_byte = 8'hFF;
        @(negedge clk_50m);
        start = 1'b0;
        wait_done(4000);
        comps++; if (lat != FULL_LAT) begin errs++; $display("FAIL ign_latency: got %0d want %0d", lat, FULL_LAT); end
        repeat (300) @(negedge clk_50m);
        comps++; if (done_cnt != 1) begin errs++; $display("FAIL ign_done_count: got %0d want 1", done_cnt); end
        comps++; if (busy !== 1'b0) begin errs++; $display("FAIL ign_busy_after: got %b want 0", busy); end
        exp_q = '{8'h78, 8'h00, 8'h5A};
        comps++; if (got_q.size() != exp_q.size()) begin errs++; $display("FAIL ign_nbytes: got %0d want %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            comps++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL ign_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back;
        accept_xfer(8'h00, 8'h12);
        wait_done(4000);
        comps++; if (lat != FULL_LAT) begin errs++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, FULL_LAT); end
        ctrl_byte = 8'h40; data_byte = 8'h55;
        @(negedge clk_50m);
        comps++; if (busy !== 1'b0) begin errs++; $display("FAIL b2b_gap_busy: got %b want 0", busy); end
        comps++; if (iic_scl !== 1'b1 || iic_sda !== 1'b1) begin errs++; $display("FAIL b2b_gap_idle: got scl=%b sda=%b want 1/1", iic_scl, iic_sda); end
        @(posedge clk_50m);
        #1;
        t_acc = cyc;
        start_cnt = 0; stop_cnt = 0; done_cnt = 0;
        got_q.delete();
        @(negedge clk_50m);
        comps++; if (busy !== 1'b1) begin errs++; $display("FAIL b2b_second_accept: got %b want 1", busy); end
        start = 1'b0;
        wait_done(4000);
        comps++; if (lat != FULL_LAT) begin errs++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, FULL_LAT); end
        repeat (5) @(negedge clk_50m);
        exp_q = '{8'h78, 8'h40, 8'h55};
        comps++; if (got_q.size() != exp_q.size()) begin errs++; $display("FAIL b2b_nbytes: got %0d want %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            comps++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        comps++; if (done_cnt != 1) begin errs++; $display("FAIL b2b_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid;
        accept_xfer(8'h00, 8'hA5);
        @(negedge clk_50m);
        start = 1'b0;
        repeat (50 * DIV) @(negedge clk_50m);
        rst_n = 1'b0;
        #1;
        comps++; if (iic_scl !== 1'b1) begin errs++; $display("FAIL mid_rst_scl: got %b want 1", iic_scl); end
        comps++; if (iic_sda !== 1'b1) begin errs++; $display("FAIL mid_rst_sda: got %b want 1", iic_sda); end
        comps++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        repeat (10) @(negedge clk_50m);
        rst_n = 1'b1;
        repeat (10) @(negedge clk_50m);
        comps++; if (done_cnt != 0) begin errs++; $display("FAIL mid_rst_no_done: got %0d want 0", done_cnt); end
        accept_xfer(8'h00, 8'hA5);
        @(negedge clk_50m);
        start = 1'b0;
        wait_done(4000);
        comps++; if (lat != FULL_LAT) begin errs++; $display("FAIL post_rst_latency: got %0d want %0d", lat, FULL_LAT); end
        repeat (5) @(negedge clk_50m);
        exp_q = '{8'h78, 8'h00, 8'hA5};
        comps++; if (got_q.size() != exp_q.size()) begin errs++; $display("FAIL post_rst_nbytes: got %0d want %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            comps++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL post_rst_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        comps++; if (stop_cnt != 1) begin errs++; $display("FAIL post_rst_stops: got %0d want 1", stop_cnt); end
    endtask

    initial begin
        test_reset();
        test_full_ack();
        test_nack_addr();
        test_ack_err_clear();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
